// File: rtl/calendar_core.sv
`default_nettype none
// ============================================================================
//  Module   : calendar_core
//  Purpose  : Gregorian date counter (year/month/day/weekday) advancing one
//             day per qualified tick, with a validated date-load handshake.
//             Weekday logic is compiled in only when CAL_WEEK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module calendar_core #(
    parameter int YEAR_W    = 14,
    parameter int YEAR_MIN  = 2020,
    parameter int YEAR_MAX  = 9999,
    parameter int WEEK_INIT = 3
) (
    input  logic              cp,
    input  logic              CR,
    input  logic              En,
    input  logic              tick,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [YEAR_W-1:0] load_year,
    input  logic [3:0]        load_month,
    input  logic [4:0]        load_day,
    output logic [YEAR_W-1:0] year,
    output logic [3:0]        month,
    output logic [4:0]        day,
    output logic              leap,
    output logic [2:0]        week,
    output logic              month_end,
    output logic              year_end,
    output logic              wrap,
    output logic              load_err
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_CHECK = 1'b1;

    localparam logic [YEAR_W-1:0] c_year_min = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] c_year_max = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] c_year_one = YEAR_W'(1);
    localparam logic [YEAR_W-1:0] c_y100     = YEAR_W'(100);
    localparam logic [YEAR_W-1:0] c_y400     = YEAR_W'(400);

    generate
        if (YEAR_MIN >= YEAR_MAX || YEAR_MAX >= (1 << YEAR_W) ||
            WEEK_INIT < 0 || WEEK_INIT > 6) begin : g_param_err
            $error("calendar_core: illegal parameter combination");
        end
    endgenerate

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        is_leap = ((y[1:0] == 2'b00) && ((y % c_y100) != '0)) ||
                  ((y % c_y400) == '0);
    endfunction

    // Constant case rather than a lookup array keeps the carry path purely combinational.
    function automatic logic [4:0] mdays(input logic [3:0] m, input logic lp);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: mdays = 5'd30;
            4'd2:                    mdays = lp ? 5'd29 : 5'd28;
            default:                 mdays = 5'd31;
        endcase
    endfunction

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [YEAR_W-1:0] r_year;
    logic [3:0]        r_month;
    logic [4:0]        r_day;
    logic              r_month_end;
    logic              r_year_end;
    logic              r_wrap;
    logic              r_load_err;
    logic [YEAR_W-1:0] r_ld_year;
    logic [3:0]        r_ld_month;
    logic [4:0]        r_ld_day;

    logic              w_leap;
    logic [4:0]        w_mdays;
    logic              w_day_last;
    logic              w_mon_last;
    logic              w_year_last;
    logic              w_accept;
    logic              w_advance;
    logic              w_check;
    logic              w_ld_ok;
    logic              w_commit;
    logic              w_reject;

    assign w_leap      = is_leap(r_year);
    assign w_mdays     = mdays(r_month, w_leap);
    assign w_day_last  = (r_day >= w_mdays);
    assign w_mon_last  = (r_month >= 4'd12);
    assign w_year_last = (r_year >= c_year_max);

    assign load_ready  = (r_state == S_RUN);
    assign w_accept    = load_valid & load_ready;
    assign w_advance   = load_ready & ~load_valid & En & tick;
    assign w_check     = (r_state == S_CHECK);

    assign w_ld_ok  = (r_ld_year >= c_year_min) && (r_ld_year <= c_year_max) &&
                      (r_ld_month != 4'd0) && (r_ld_month <= 4'd12) &&
                      (r_ld_day != 5'd0) &&
                      (r_ld_day <= mdays(r_ld_month, is_leap(r_ld_year)));
    assign w_commit = w_check & w_ld_ok;
    assign w_reject = w_check & ~w_ld_ok;

    always_ff @(posedge cp) begin
        if (CR) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (load_valid) w_state_next = S_CHECK;
            S_CHECK: w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge cp) begin
        if (CR) begin
            r_year      <= c_year_min;
            r_month     <= 4'd1;
            r_day       <= 5'd1;
            r_month_end <= 1'b0;
            r_year_end  <= 1'b0;
            r_wrap      <= 1'b0;
            r_load_err  <= 1'b0;
            r_ld_year   <= '0;
            r_ld_month  <= 4'd0;
            r_ld_day    <= 5'd0;
        end else begin
            r_month_end <= 1'b0;
            r_year_end  <= 1'b0;
            r_wrap      <= 1'b0;
            r_load_err  <= w_reject;
            if (w_accept) begin
                r_ld_year  <= load_year;
                r_ld_month <= load_month;
                r_ld_day   <= load_day;
            end
            if (w_commit) begin
                r_year  <= r_ld_year;
                r_month <= r_ld_month;
                r_day   <= r_ld_day;
            end else if (w_advance) begin
                if (!w_day_last) begin
                    r_day <= r_day + 5'd1;
                end else begin
                    r_day       <= 5'd1;
                    r_month_end <= 1'b1;
                    if (!w_mon_last) begin
                        r_month <= r_month + 4'd1;
                    end else begin
                        r_month    <= 4'd1;
                        r_year_end <= 1'b1;
                        if (!w_year_last) begin
                            r_year <= r_year + c_year_one;
                        end else begin
                            r_year <= c_year_min;
                            r_wrap <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef CAL_WEEK_EN
    localparam logic [2:0]        c_week_init = 3'(WEEK_INIT);
    localparam logic [YEAR_W+1:0] c_d1        = (YEAR_W+2)'(1);
    localparam logic [YEAR_W+1:0] c_d7        = (YEAR_W+2)'(7);
    localparam logic [YEAR_W+1:0] c_d100      = (YEAR_W+2)'(100);
    localparam logic [YEAR_W+1:0] c_d400      = (YEAR_W+2)'(400);

    // Sakamoto: shift Jan/Feb into the previous year so leap days fall at year end.
    function automatic logic [2:0] dow(input logic [YEAR_W-1:0] y,
                                       input logic [3:0] m,
                                       input logic [4:0] d);
        logic [YEAR_W+1:0] ya;
        logic [YEAR_W+1:0] sum;
        logic [YEAR_W+1:0] rem;
        logic [2:0]        t;
        case (m)
            4'd1:    t = 3'd0;
            4'd2:    t = 3'd3;
            4'd3:    t = 3'd2;
            4'd4:    t = 3'd5;
            4'd5:    t = 3'd0;
            4'd6:    t = 3'd3;
            4'd7:    t = 3'd5;
            4'd8:    t = 3'd1;
            4'd9:    t = 3'd4;
            4'd10:   t = 3'd6;
            4'd11:   t = 3'd2;
            default: t = 3'd4;
        endcase
        ya  = {2'b00, y} - ((m < 4'd3) ? c_d1 : '0);
        sum = ya + (ya >> 2) - (ya / c_d100) + (ya / c_d400) +
              {{(YEAR_W-1){1'b0}}, t} + {{(YEAR_W-3){1'b0}}, d};
        rem = sum % c_d7;
        dow = rem[2:0];
    endfunction

    logic [2:0] r_week;
    logic [2:0] w_ld_week;

    assign w_ld_week = dow(r_ld_year, r_ld_month, r_ld_day);

    always_ff @(posedge cp) begin
        if (CR) begin
            r_week <= c_week_init;
        end else if (w_commit) begin
            r_week <= w_ld_week;
        end else if (w_advance) begin
            r_week <= (r_week == 3'd6) ? 3'd0 : r_week + 3'd1;
        end
    end

    assign week = r_week;
`else
    assign week = 3'd0;
`endif

    assign year      = r_year;
    assign month     = r_month;
    assign day       = r_day;
    assign leap      = w_leap;
    assign month_end = r_month_end;
    assign year_end  = r_year_end;
    assign wrap      = r_wrap;
    assign load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_calendar_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calendar_core
//  Purpose  : Directed self-checking bench for calendar_core (default range
//             plus a YEAR_MIN=2000 instance for the century leap rule).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calendar_core;

`ifdef CAL_WEEK_EN
    localparam bit WK = 1'b1;
`else
    localparam bit WK = 1'b0;
`endif

    logic        cp = 1'b0;
    logic        CR = 1'b1;
    logic        En = 1'b0;
    logic        tick = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [13:0] load_year = '0;
    logic [3:0]  load_month = '0;
    logic [4:0]  load_day = '0;
    logic [13:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic        leap;
    logic [2:0]  week;
    logic        month_end, year_end, wrap, load_err;

    logic        En_b = 1'b0;
    logic        tick_b = 1'b0;
    logic        load_valid_b = 1'b0;
    logic        load_ready_b;
    logic [13:0] load_year_b = '0;
    logic [3:0]  load_month_b = '0;
    logic [4:0]  load_day_b = '0;
    logic [13:0] year_b;
    logic [3:0]  month_b;
    logic [4:0]  day_b;
    logic        leap_b;
    logic [2:0]  week_b;
    logic        month_end_b, year_end_b, wrap_b, load_err_b;

    int n_cmp  = 0;
    int n_fail = 0;

    calendar_core dut (
        .cp(cp), .CR(CR), .En(En), .tick(tick),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_year(load_year), .load_month(load_month), .load_day(load_day),
        .year(year), .month(month), .day(day), .leap(leap), .week(week),
        .month_end(month_end), .year_end(year_end), .wrap(wrap), .load_err(load_err)
    );

    calendar_core #(.YEAR_MIN(2000), .WEEK_INIT(6)) dut_b (
        .cp(cp), .CR(CR), .En(En_b), .tick(tick_b),
        .load_valid(load_valid_b), .load_ready(load_ready_b),
        .load_year(load_year_b), .load_month(load_month_b), .load_day(load_day_b),
        .year(year_b), .month(month_b), .day(day_b), .leap(leap_b), .week(week_b),
        .month_end(month_end_b), .year_end(year_end_b), .wrap(wrap_b), .load_err(load_err_b)
    );

    always #5 cp = ~cp;

    function automatic logic [2:0] ew(input int v);
        return WK ? 3'(v) : 3'd0;
    endfunction

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    // Presents a request for one accept edge; returns in the CHECK cycle.
    task automatic load_req(input int y, input int m, input int d);
        load_valid = 1'b1;
        load_year  = 14'(y);
        load_month = 4'(m);
        load_day   = 5'(d);
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        CR = 1'b1;
        step();
        step();
        CR = 1'b0;
        step();
        n_cmp++;
        if ({year, month, day} !== {14'd2020, 4'd1, 5'd1}) begin
            n_fail++;
            $display("FAIL reset_date: got %0d-%0d-%0d want 2020-1-1", year, month, day);
        end
        n_cmp++;
        if ({leap, week, load_ready} !== {1'b1, ew(3), 1'b1}) begin
            n_fail++;
            $display("FAIL reset_flags: got leap=%b week=%0d ready=%b want 1 %0d 1", leap, week, load_ready, ew(3));
        end
        n_cmp++;
        if ({month_end, year_end, wrap, load_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b%b%b%b want 0000", month_end, year_end, wrap, load_err);
        end
    endtask

    task automatic test_year_count();
        int me = 0;
        int ye = 0;
        En   = 1'b1;
        tick = 1'b1;
        repeat (365) begin
            step();
            me += int'(month_end);
            ye += int'(year_end);
        end
        n_cmp++;
        if ({year, month, day} !== {14'd2020, 4'd12, 5'd31} || me != 11 || ye != 0) begin
            n_fail++;
            $display("FAIL year_365: got %0d-%0d-%0d me=%0d ye=%0d want 2020-12-31 me=11 ye=0", year, month, day, me, ye);
        end
        step();
        me += int'(month_end);
        ye += int'(year_end);
        tick = 1'b0;
        n_cmp++;
        if ({year, month, day} !== {14'd2021, 4'd1, 5'd1} || me != 12 || ye != 1) begin
            n_fail++;
            $display("FAIL year_366: got %0d-%0d-%0d me=%0d ye=%0d want 2021-1-1 me=12 ye=1", year, month, day, me, ye);
        end
        n_cmp++;
        if ({week, leap} !== {ew(5), 1'b0}) begin
            n_fail++;
            $display("FAIL year_week: got week=%0d leap=%b want %0d 0", week, leap, ew(5));
        end
    endtask

    task automatic test_leap();
        load_req(2100, 2, 28);
        n_cmp++;
        if (load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL check_ready: got %b want 0", load_ready);
        end
        step();
        n_cmp++;
        if ({year, month, day, leap, load_err} !== {14'd2100, 4'd2, 5'd28, 1'b0, 1'b0} || week !== ew(0)) begin
            n_fail++;
            $display("FAIL load_2100: got %0d-%0d-%0d leap=%b err=%b week=%0d", year, month, day, leap, load_err, week);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_cmp++;
        if ({year, month, day, leap} !== {14'd2100, 4'd3, 5'd1, 1'b0} || week !== ew(1)) begin
            n_fail++;
            $display("FAIL tick_2100: got %0d-%0d-%0d leap=%b week=%0d want 2100-3-1 leap=0", year, month, day, leap, week);
        end
        load_valid_b = 1'b1;
        load_year_b  = 14'd2000;
        load_month_b = 4'd2;
        load_day_b   = 5'd28;
        step();
        load_valid_b = 1'b0;
        step();
        n_cmp++;
        if ({year_b, month_b, day_b, leap_b, load_err_b} !== {14'd2000, 4'd2, 5'd28, 1'b1, 1'b0} || week_b !== ew(1)) begin
            n_fail++;
            $display("FAIL load_2000: got %0d-%0d-%0d leap=%b err=%b week=%0d", year_b, month_b, day_b, leap_b, load_err_b, week_b);
        end
        En_b   = 1'b1;
        tick_b = 1'b1;
        step();
        tick_b = 1'b0;
        n_cmp++;
        if ({year_b, month_b, day_b} !== {14'd2000, 4'd2, 5'd29} || week_b !== ew(2)) begin
            n_fail++;
            $display("FAIL tick_2000: got %0d-%0d-%0d week=%0d want 2000-2-29", year_b, month_b, day_b, week_b);
        end
    endtask

    task automatic test_wrap();
        load_req(9999, 12, 31);
        step();
        n_cmp++;
        if ({year, month, day} !== {14'd9999, 4'd12, 5'd31} || week !== ew(5)) begin
            n_fail++;
            $display("FAIL load_9999: got %0d-%0d-%0d week=%0d want 9999-12-31", year, month, day, week);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_cmp++;
        if ({year, month, day, leap} !== {14'd2020, 4'd1, 5'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_date: got %0d-%0d-%0d leap=%b want 2020-1-1 leap=1", year, month, day, leap);
        end
        n_cmp++;
        if ({wrap, year_end, month_end} !== 3'b111) begin
            n_fail++;
            $display("FAIL wrap_pulses: got %b%b%b want 111", wrap, year_end, month_end);
        end
        step();
        n_cmp++;
        if ({wrap, year_end, month_end} !== 3'b000) begin
            n_fail++;
            $display("FAIL wrap_one_cycle: got %b%b%b want 000", wrap, year_end, month_end);
        end
    endtask

    task automatic test_invalid_load();
        int ys[3] = '{2023, 2019, 2024};
        int ms[3] = '{2, 5, 13};
        int ds[3] = '{29, 5, 1};
        for (int i = 0; i < 3; i++) begin
            load_req(ys[i], ms[i], ds[i]);
            n_cmp++;
            if (load_err !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_early_%0d: got err=%b want 0", i, load_err);
            end
            step();
            n_cmp++;
            if ({load_err, year, month, day} !== {1'b1, 14'd2020, 4'd1, 5'd1}) begin
                n_fail++;
                $display("FAIL bad_load_%0d: got err=%b %0d-%0d-%0d want err=1 2020-1-1", i, load_err, year, month, day);
            end
            step();
            n_cmp++;
            if (load_err !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_pulse_%0d: got err=%b want 0", i, load_err);
            end
        end
        load_req(2024, 2, 29);
        step();
        n_cmp++;
        if ({load_err, year, month, day, leap} !== {1'b0, 14'd2024, 4'd2, 5'd29, 1'b1} || week !== ew(4)) begin
            n_fail++;
            $display("FAIL load_2024: got err=%b %0d-%0d-%0d leap=%b week=%0d", load_err, year, month, day, leap, week);
        end
    endtask

    task automatic test_pause();
        En   = 1'b0;
        tick = 1'b1;
        repeat (10) step();
        tick = 1'b0;
        En   = 1'b1;
        n_cmp++;
        if ({year, month, day} !== {14'd2024, 4'd2, 5'd29} || week !== ew(4)) begin
            n_fail++;
            $display("FAIL pause: got %0d-%0d-%0d week=%0d want 2024-2-29", year, month, day, week);
        end
    endtask

    task automatic test_conflict();
        En         = 1'b1;
        tick       = 1'b1;
        load_valid = 1'b1;
        load_year  = 14'd2024;
        load_month = 4'd3;
        load_day   = 5'd10;
        step();
        n_cmp++;
        if ({year, month, day, load_ready} !== {14'd2024, 4'd2, 5'd29, 1'b0}) begin
            n_fail++;
            $display("FAIL accept_tick: got %0d-%0d-%0d ready=%b want 2024-2-29 ready=0", year, month, day, load_ready);
        end
        step();
        load_valid = 1'b0;
        tick       = 1'b0;
        n_cmp++;
        if ({year, month, day, load_ready, load_err} !== {14'd2024, 4'd3, 5'd10, 1'b1, 1'b0} || week !== ew(0)) begin
            n_fail++;
            $display("FAIL check_tick: got %0d-%0d-%0d ready=%b err=%b week=%0d want 2024-3-10", year, month, day, load_ready, load_err, week);
        end
        step();
        n_cmp++;
        if ({year, month, day, load_ready} !== {14'd2024, 4'd3, 5'd10, 1'b1} || week !== ew(0)) begin
            n_fail++;
            $display("FAIL no_reaccept: got %0d-%0d-%0d ready=%b week=%0d", year, month, day, load_ready, week);
        end
    endtask

    task automatic test_reset_mid_check();
        load_req(2030, 6, 15);
        CR = 1'b1;
        step();
        CR = 1'b0;
        n_cmp++;
        if ({year, month, day, load_err} !== {14'd2020, 4'd1, 5'd1, 1'b0} || week !== ew(3)) begin
            n_fail++;
            $display("FAIL rst_check: got %0d-%0d-%0d err=%b week=%0d want 2020-1-1 err=0", year, month, day, load_err, week);
        end
        step();
        n_cmp++;
        if ({year, month, day, load_err, load_ready} !== {14'd2020, 4'd1, 5'd1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_after: got %0d-%0d-%0d err=%b ready=%b want 2020-1-1 0 1", year, month, day, load_err, load_ready);
        end
    endtask

    initial begin
        test_reset();
        test_year_count();
        test_leap();
        test_wrap();
        test_invalid_load();
        test_pause();
        test_conflict();
        test_reset_mid_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calendar_core.md
# calendar_core

Parametrised Gregorian date counter with one clock, advancing one day per qualified `tick`. It keeps year/month/day with leap-year and month-length logic, an incremental weekday, carry pulses for downstream display and alarm logic, and a validated synchronous date-load handshake. It is the next-generation replacement for the fixed-range cascaded day/month/year counter. BCD conversion for display stays in the existing converters downstream.

## Interface
- `YEAR_W`, 14: year counter width; must hold `YEAR_MAX`.
- `YEAR_MIN`, 2020: first year; reset and wrap target.
- `YEAR_MAX`, 9999: last year; must satisfy `YEAR_MIN < YEAR_MAX < 2**YEAR_W`.
- `WEEK_INIT`, 3: weekday of `YEAR_MIN`-01-01, where 0=Sunday … 6=Saturday. The default is 3 (Wednesday, 2020-01-01).
- `cp` input 1: clock; all state updates on its rising edge.
- `CR` input 1: reset, synchronous, active-high.
- `En` input 1: count enable; when low, `tick` is ignored (pause).
- `tick` input 1: advance one day when `En` is high and the FSM is in RUN.
- `load_valid` input 1: load request.
- `load_ready` output 1: high only in RUN.
- `load_year` input YEAR_W: year to load.
- `load_month` input 4: month to load.
- `load_day` input 5: day to load.
- `year` output YEAR_W: current year, binary.
- `month` output 4: current month, 1–12.
- `day` output 5: current day, 1–31.
- `leap` output 1: current year is a leap year.
- `week` output 3: weekday, 0–6.
- `month_end` output 1: one-cycle pulse on rollover into a new month.
- `year_end` output 1: one-cycle pulse on rollover into a new year.
- `wrap` output 1: one-cycle pulse on rollover from `YEAR_MAX`-12-31 to `YEAR_MIN`-01-01.
- `load_err` output 1: one-cycle pulse when a load is rejected.

## Operation
FSM states:
- **RUN**
  - A load is accepted when `load_valid` and `load_ready` are both high. The request is captured and the FSM moves to CHECK.
  - Otherwise, if `En && tick`, the date advances.
- **CHECK** (exactly 1 cycle) validates the captured date. The date is valid when:
  - `YEAR_MIN ≤ y ≤ YEAR_MAX`,
  - `1 ≤ m ≤ 12`,
  - `1 ≤ d ≤ mdays(m, y)`.
  - Valid: commit the date, recompute `week` (see Configuration), return to RUN.
  - Invalid: keep the old date, pulse `load_err`, return to RUN.

Arithmetic and date rules:
- `leap` = `(y%4==0 && y%100!=0) || y%400==0`, evaluated on the current `year` register.
- `mdays` is a constant case on month: 31/30, with February giving 28 or 29 by the leap rule. It is not a memory array, so the carry path has no array-access race.
- Day advance:
  - If `day < mdays`, then `day+1`.
  - Else `day=1`, pulse `month_end`; then, if `month < 12`, `month+1`.
  - Else `month=1`, pulse `year_end`; then, if `year < YEAR_MAX`, `year+1`.
  - Else `year=YEAR_MIN`, pulse `wrap`.
- `week` advances as `(week+1) mod 7` on every advance.
- All carries are computed in one cycle from the registered state. There is no ripple clocking.

## Timing
- Reset values:
  - `year=YEAR_MIN`, `month=1`, `day=1`, `week=WEEK_INIT`, FSM=RUN.
  - All pulses are 0; `load_ready=1` in the cycle after reset deasserts.
- Tick latency: registered outputs show the new date 1 cycle after the sampling edge. Pulses are asserted in that same cycle.
- Load latency: committed date, or the `load_err` pulse, is visible 2 cycles after the accept edge.
- `load_ready` is low during CHECK. `load_valid` in that cycle is not accepted, and the requester must hold it.
- Simultaneous events:
  - Accept and tick in the same cycle: the load wins and the tick is dropped.
  - A tick during CHECK is dropped.
- `CR` mid-CHECK aborts the load with no `load_err`; reset wins over everything.
- `leap` is combinational from `year`. It updates in the same cycle as `year`.

## Configuration
- `CAL_WEEK_EN` defined:
  - The weekday logic is compiled in.
  - CHECK computes `week` from the loaded date with Sakamoto's method, in one combinational stage mod 7.
- `CAL_WEEK_EN` undefined:
  - No weekday register or adder.
  - `week` is tied to 0.
  - Load and timing are otherwise identical.

## Test plan
- Reset, then 365 ticks with `En=1`:
  - 2020 is a leap year, so the date is 2020-12-31; one more tick gives 2021-01-01.
  - `year_end` pulses once, `month_end` 12 times in total.
  - `week` = 5 (Friday).
- Leap rules:
  - Load 2100-02-28, then tick → 2100-03-01, `leap=0`.
  - Load 2000-02-28 with `YEAR_MIN=2000`, then tick → 2000-02-29.
- Wrap: load 9999-12-31, then tick → 2020-01-01, with `wrap`, `year_end` and `month_end` all pulsing in the same cycle.
- Invalid loads:
  - Load 2023-02-29, 2019-05-05 or 2024-13-01 → `load_err` pulses 2 cycles after accept; the date is unchanged.
  - Load 2024-02-29 → accepted, `week=4` with `CAL_WEEK_EN`.
- Pause and conflicts:
  - With `En=0` and 10 ticks, the date is unchanged.
  - A tick in the accept cycle and in the CHECK cycle are both ignored.
  - `load_valid` held in CHECK is not double-accepted.
- Reset mid-operation: `CR` in the CHECK cycle → reset date, no `load_err`, `load_ready=1` in the cycle after reset deasserts.
